if_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that replaces the free-running PC counter with a handshaked fetch engine. Holds the architectural fetch PC, issues one memory request at a time to the memory controller, and buffers the returned instruction until ID accepts it. Takes branch/jump redirects from EX, including while a request is in flight, and discards stale responses. Sits between the memory controller and ID.

---
 rtl/if_fetch_unit_pkg.sv | 12 +
 rtl/if_fetch_unit_if.sv | 26 ++
 rtl/if_fetch_unit.sv | 105 ++++++++++
 tb/tb_if_fetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage.
// Holds the 2-bit fetch state encoding.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: memory request/response channel and the ID hand-off.
// The master side is the fetch unit; the slave side is memory controller plus ID.
interface if_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [INST_W-1:0] mem_rdata_i;
    logic              id_valid_o;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic              id_ready_i;

    modport master (
        output mem_req_o, mem_addr_o, id_valid_o, id_pc_o, id_inst_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, id_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, id_valid_o, id_pc_o, id_inst_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, id_ready_i
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Handshaked instruction fetch: one outstanding memory request, a one-entry
// output buffer toward ID, and redirect handling that discards stale responses.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                redirect_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i,
    output logic                busy_o,
    if_fetch_unit_if.master     fetch_bus
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(PC_STEP - 1);

    fetch_state_e      r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic              r_drop, w_drop_next;
    logic [ADDR_W-1:0] r_buf_pc, w_buf_pc_next;
    logic [INST_W-1:0] r_buf_inst, w_buf_inst_next;
    logic [ADDR_W-1:0] w_target;

    assign w_target = redirect_pc_i & ~ALIGN_MASK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_buf_pc   <= '0;
            r_buf_inst <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_drop     <= w_drop_next;
            r_buf_pc   <= w_buf_pc_next;
            r_buf_inst <= w_buf_inst_next;
        end
    end

    // With rdy low every default holds, so the whole stage freezes.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_drop_next     = r_drop;
        w_buf_pc_next   = r_buf_pc;
        w_buf_inst_next = r_buf_inst;
        if (rdy) begin
            case (r_state)
                S_IDLE: w_state_next = S_REQ;
                S_REQ: begin
                    if (redirect_i)
                        w_pc_next = w_target;
                    if (fetch_bus.mem_gnt_i) begin
                        w_state_next = S_WAIT;
                        if (redirect_i)
                            w_drop_next = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (redirect_i) begin
                        w_pc_next   = w_target;
                        w_drop_next = 1'b1;
                    end
                    if (fetch_bus.mem_rvalid_i) begin
                        if (r_drop || redirect_i) begin
                            w_drop_next  = 1'b0;
                            w_state_next = S_REQ;
                        end else begin
                            w_buf_pc_next   = r_pc;
                            w_buf_inst_next = fetch_bus.mem_rdata_i;
                            w_state_next    = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // A redirect kills the buffered instruction even if ID is ready.
                    if (redirect_i) begin
                        w_pc_next    = w_target;
                        w_state_next = S_REQ;
                    end else if (fetch_bus.id_ready_i) begin
                        w_pc_next    = r_pc + STEP;
                        w_state_next = S_REQ;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign fetch_bus.mem_req_o  = (r_state == S_REQ);
    assign fetch_bus.mem_addr_o = r_pc;
    assign fetch_bus.id_valid_o = (r_state == S_HOLD);
    assign fetch_bus.id_pc_o    = r_buf_pc;
    assign fetch_bus.id_inst_o  = r_buf_inst;
    assign busy_o               = (r_state == S_WAIT);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset PC, streaming, redirects, stall and wrap.
// Three instances cover RESET_PC=0, RESET_PC=0x100 and an 8-bit wrapping PC.
module tb_if_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Instance A: RESET_PC = 0
    logic        rst_a, rdy_a, redir_a, busy_a;
    logic [31:0] redir_pc_a;
    if_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) a_bus ();
    if_fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0), .PC_STEP(4)) u_a (
        .clk(clk), .rst(rst_a), .rdy(rdy_a), .redirect_i(redir_a),
        .redirect_pc_i(redir_pc_a), .busy_o(busy_a), .fetch_bus(a_bus.master));

    // Instance B: RESET_PC = 0x100
    logic        rst_b, rdy_b, redir_b, busy_b;
    logic [31:0] redir_pc_b;
    if_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) b_bus ();
    if_fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h100), .PC_STEP(4)) u_b (
        .clk(clk), .rst(rst_b), .rdy(rdy_b), .redirect_i(redir_b),
        .redirect_pc_i(redir_pc_b), .busy_o(busy_b), .fetch_bus(b_bus.master));

    // Instance C: 8-bit PC starting near the top of the address space
    logic       rst_c, rdy_c, redir_c, busy_c;
    logic [7:0] redir_pc_c;
    if_fetch_unit_if #(.ADDR_W(8), .INST_W(32)) c_bus ();
    if_fetch_unit #(.ADDR_W(8), .INST_W(32), .RESET_PC(8'hFC), .PC_STEP(4)) u_c (
        .clk(clk), .rst(rst_c), .rdy(rdy_c), .redirect_i(redir_c),
        .redirect_pc_i(redir_pc_c), .busy_o(busy_c), .fetch_bus(c_bus.master));

    initial begin
        rst_a = 1; rst_b = 1; rst_c = 1;
        rdy_a = 1; rdy_b = 1; rdy_c = 1;
        redir_a = 0; redir_b = 0; redir_c = 0;
        redir_pc_a = '0; redir_pc_b = '0; redir_pc_c = '0;
        a_bus.mem_gnt_i = 0; a_bus.mem_rvalid_i = 0; a_bus.mem_rdata_i = '0; a_bus.id_ready_i = 0;
        b_bus.mem_gnt_i = 0; b_bus.mem_rvalid_i = 0; b_bus.mem_rdata_i = '0; b_bus.id_ready_i = 0;
        c_bus.mem_gnt_i = 0; c_bus.mem_rvalid_i = 0; c_bus.mem_rdata_i = '0; c_bus.id_ready_i = 0;
        step(); step();

        // Reset values
        chk("rst_req",   32'(a_bus.mem_req_o),  32'd0);
        chk("rst_addr",  a_bus.mem_addr_o,      32'h0);
        chk("rst_valid", 32'(a_bus.id_valid_o), 32'd0);
        chk("rst_idpc",  a_bus.id_pc_o,         32'h0);
        chk("rst_inst",  a_bus.id_inst_o,       32'h0);
        chk("rst_busy",  32'(busy_a),           32'd0);
        chk("rst_addr_b", b_bus.mem_addr_o,     32'h100);
        chk("rst_addr_c", 32'(c_bus.mem_addr_o), 32'hFC);

        // Reset PC and best-case latency on B
        rst_b = 0;
        step();
        chk("b_req",  32'(b_bus.mem_req_o), 32'd1);
        chk("b_addr", b_bus.mem_addr_o,     32'h100);
        b_bus.mem_gnt_i = 1;
        step();
        chk("b_busy", 32'(busy_b), 32'd1);
        b_bus.mem_gnt_i = 0; b_bus.mem_rvalid_i = 1; b_bus.mem_rdata_i = 32'hDEADBEEF;
        step();
        b_bus.mem_rvalid_i = 0;
        chk("b_valid", 32'(b_bus.id_valid_o), 32'd1);
        chk("b_idpc",  b_bus.id_pc_o,         32'h100);
        chk("b_inst",  b_bus.id_inst_o,       32'hDEADBEEF);

        // Wrap and redirect alignment on C
        rst_c = 0;
        step();
        chk("c_addr0", 32'(c_bus.mem_addr_o), 32'hFC);
        c_bus.mem_gnt_i = 1;
        step();
        c_bus.mem_gnt_i = 0; c_bus.mem_rvalid_i = 1; c_bus.mem_rdata_i = 32'h11;
        step();
        c_bus.mem_rvalid_i = 0;
        chk("c_idpc", 32'(c_bus.id_pc_o), 32'hFC);
        c_bus.id_ready_i = 1;
        step();
        c_bus.id_ready_i = 0;
        chk("c_wrap", 32'(c_bus.mem_addr_o), 32'h00);
        redir_c = 1; redir_pc_c = 8'h13;
        step();
        redir_c = 0;
        chk("c_align", 32'(c_bus.mem_addr_o), 32'h10);
        chk("c_req",   32'(c_bus.mem_req_o),  32'd1);

        // Streaming on A: one instruction every 3 cycles
        rst_a = 0;
        a_bus.id_ready_i = 1;
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s%0d_req", k),  32'(a_bus.mem_req_o), 32'd1);
            chk($sformatf("s%0d_addr", k), a_bus.mem_addr_o,     32'(4 * k));
            a_bus.mem_gnt_i = 1;
            step();
            a_bus.mem_gnt_i = 0; a_bus.mem_rvalid_i = 1; a_bus.mem_rdata_i = 32'h1000 + 32'(k);
            step();
            a_bus.mem_rvalid_i = 0;
            chk($sformatf("s%0d_valid", k), 32'(a_bus.id_valid_o), 32'd1);
            chk($sformatf("s%0d_idpc", k),  a_bus.id_pc_o,         32'(4 * k));
            chk($sformatf("s%0d_inst", k),  a_bus.id_inst_o,       32'h1000 + 32'(k));
            step();
        end
        a_bus.id_ready_i = 0;

        // Redirect while waiting for the response
        chk("w_addr", a_bus.mem_addr_o, 32'h10);
        a_bus.mem_gnt_i = 1;
        step();
        a_bus.mem_gnt_i = 0; redir_a = 1; redir_pc_a = 32'h2000;
        step();
        redir_a = 0;
        chk("w_busy",  32'(busy_a),            32'd1);
        chk("w_valid", 32'(a_bus.id_valid_o),  32'd0);
        a_bus.mem_rvalid_i = 1; a_bus.mem_rdata_i = 32'hBAD0BAD0;
        step();
        a_bus.mem_rvalid_i = 0;
        chk("w_valid2", 32'(a_bus.id_valid_o), 32'd0);
        chk("w_req",    32'(a_bus.mem_req_o),  32'd1);
        chk("w_target", a_bus.mem_addr_o,      32'h2000);

        // Redirect in the grant cycle
        a_bus.mem_gnt_i = 1; redir_a = 1; redir_pc_a = 32'h3000;
        step();
        a_bus.mem_gnt_i = 0; redir_a = 0;
        chk("g_busy", 32'(busy_a), 32'd1);
        a_bus.mem_rvalid_i = 1; a_bus.mem_rdata_i = 32'hBAD1BAD1;
        step();
        a_bus.mem_rvalid_i = 0;
        chk("g_valid",  32'(a_bus.id_valid_o), 32'd0);
        chk("g_req",    32'(a_bus.mem_req_o),  32'd1);
        chk("g_target", a_bus.mem_addr_o,      32'h3000);

        // Redirect in the rvalid cycle
        a_bus.mem_gnt_i = 1;
        step();
        a_bus.mem_gnt_i = 0;
        a_bus.mem_rvalid_i = 1; a_bus.mem_rdata_i = 32'hBAD2BAD2;
        redir_a = 1; redir_pc_a = 32'h4000;
        step();
        a_bus.mem_rvalid_i = 0; redir_a = 0;
        chk("r_valid",  32'(a_bus.id_valid_o), 32'd0);
        chk("r_req",    32'(a_bus.mem_req_o),  32'd1);
        chk("r_target", a_bus.mem_addr_o,      32'h4000);

        // Backpressure then global stall while holding an instruction
        a_bus.mem_gnt_i = 1;
        step();
        a_bus.mem_gnt_i = 0; a_bus.mem_rvalid_i = 1; a_bus.mem_rdata_i = 32'hCAFE0001;
        step();
        a_bus.mem_rvalid_i = 0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_valid", k), 32'(a_bus.id_valid_o), 32'd1);
            chk($sformatf("bp%0d_idpc", k),  a_bus.id_pc_o,         32'h4000);
            chk($sformatf("bp%0d_inst", k),  a_bus.id_inst_o,       32'hCAFE0001);
            step();
        end
        rdy_a = 0; a_bus.id_ready_i = 1; redir_a = 1; redir_pc_a = 32'h7000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("st%0d_valid", k), 32'(a_bus.id_valid_o), 32'd1);
            chk($sformatf("st%0d_idpc", k),  a_bus.id_pc_o,         32'h4000);
            chk($sformatf("st%0d_inst", k),  a_bus.id_inst_o,       32'hCAFE0001);
            chk($sformatf("st%0d_pc", k),    a_bus.mem_addr_o,      32'h4000);
        end
        rdy_a = 1; a_bus.id_ready_i = 0; redir_a = 0;
        step();
        chk("st_after_valid", 32'(a_bus.id_valid_o), 32'd1);
        chk("st_after_pc",    a_bus.mem_addr_o,      32'h4000);

        // Redirect in HOLD beats id_ready
        redir_a = 1; redir_pc_a = 32'h5000; a_bus.id_ready_i = 1;
        step();
        redir_a = 0; a_bus.id_ready_i = 0;
        chk("h_valid",  32'(a_bus.id_valid_o), 32'd0);
        chk("h_target", a_bus.mem_addr_o,      32'h5000);
        a_bus.mem_gnt_i = 1;
        step();
        a_bus.mem_gnt_i = 0; a_bus.mem_rvalid_i = 1; a_bus.mem_rdata_i = 32'h00000055;
        step();
        a_bus.mem_rvalid_i = 0;
        chk("h_idpc", a_bus.id_pc_o,    32'h5000);
        chk("h_inst", a_bus.id_inst_o,  32'h00000055);
        a_bus.id_ready_i = 1;
        step();
        a_bus.id_ready_i = 0;
        chk("h_next", a_bus.mem_addr_o, 32'h5004);

        // Asynchronous reset in the middle of a request
        a_bus.mem_gnt_i = 1;
        step();
        a_bus.mem_gnt_i = 0;
        chk("ar_busy_pre", 32'(busy_a), 32'd1);
        #2 rst_a = 1;
        #1;
        chk("ar_busy",  32'(busy_a),            32'd0);
        chk("ar_req",   32'(a_bus.mem_req_o),   32'd0);
        chk("ar_addr",  a_bus.mem_addr_o,       32'h0);
        chk("ar_valid", 32'(a_bus.id_valid_o),  32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
